// File: rtl/fusion_dot_seq_if.sv
// Handshake and fusion-unit bus for fusion_dot_seq.
// master = operand/result side, slave = the sequencer.
interface fusion_dot_seq_if #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_in_width;
  logic [2:0]       cfg_weight_width;
  logic             cfg_s_in;
  logic             cfg_s_weight;
  logic [LEN_W-1:0] cfg_len;
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_in;
  logic [3:0]       op_weight;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_ovf;
  logic [3:0]       fu_in;
  logic [3:0]       fu_weight;
  logic [2:0]       fu_in_width;
  logic [2:0]       fu_weight_width;
  logic             fu_s_in;
  logic             fu_s_weight;
  logic [7:0]       fu_psum;

  modport master (
    output cfg_valid, cfg_in_width, cfg_weight_width,
    output cfg_s_in, cfg_s_weight, cfg_len,
    input  cfg_ready,
    output op_valid, op_in, op_weight,
    input  op_ready,
    input  res_valid, res_data, res_ovf,
    output res_ready,
    input  fu_in, fu_weight, fu_in_width, fu_weight_width,
    input  fu_s_in, fu_s_weight,
    output fu_psum
  );

  modport slave (
    input  cfg_valid, cfg_in_width, cfg_weight_width,
    input  cfg_s_in, cfg_s_weight, cfg_len,
    output cfg_ready,
    input  op_valid, op_in, op_weight,
    output op_ready,
    output res_valid, res_data, res_ovf,
    input  res_ready,
    output fu_in, fu_weight, fu_in_width, fu_weight_width,
    output fu_s_in, fu_s_weight,
    input  fu_psum
  );
endinterface

// File: rtl/fusion_dot_seq.sv
// Dot-product sequencer for one 4-bit fusion unit.
// Define FUSION_SEQ_SAT_EN to clamp the accumulator on overflow.
module fusion_dot_seq #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  fusion_dot_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_nxt;
  logic             v1_q;
  logic             v2_q;
  logic             sgn_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             cfg_ready_q;
  logic             op_ready_q;
  logic             res_valid_q;

  logic             cfg_hs;
  logic             op_hs;
  logic             res_hs;
  logic [ACC_W-1:0] psum_ext;
  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_nxt;

  assign cfg_hs  = bus.cfg_valid & cfg_ready_q & (state == IDLE);
  assign op_hs   = bus.op_valid & op_ready_q;
  assign res_hs  = res_valid_q & bus.res_ready;
  assign cnt_nxt = cnt_q + LEN_W'(1);

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = acc_q;
  assign bus.res_ovf   = ovf_q;

  // Extend the tagged psum and add it, flagging range overflow
  always_comb begin
    psum_ext = sgn_q ? {{(ACC_W-8){bus.fu_psum[7]}}, bus.fu_psum}
                     : {{(ACC_W-8){1'b0}}, bus.fu_psum};
    sum_w    = {1'b0, acc_q} + {1'b0, psum_ext};
    sum      = sum_w[ACC_W-1:0];
    if (sgn_q)
      add_ovf = (acc_q[ACC_W-1] == psum_ext[ACC_W-1]) &&
                (sum[ACC_W-1] != acc_q[ACC_W-1]);
    else
      add_ovf = sum_w[ACC_W];
`ifdef FUSION_SEQ_SAT_EN
    if (!add_ovf)
      acc_nxt = sum;
    else if (!sgn_q)
      acc_nxt = '1;
    else if (acc_q[ACC_W-1])
      acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
    else
      acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
`else
    acc_nxt = sum;
`endif
  end

  // Job FSM, operand pipe, accumulator and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      len_q               <= '0;
      cnt_q               <= '0;
      v1_q                <= 1'b0;
      v2_q                <= 1'b0;
      sgn_q               <= 1'b0;
      acc_q               <= '0;
      ovf_q               <= 1'b0;
      cfg_ready_q         <= 1'b0;
      op_ready_q          <= 1'b0;
      res_valid_q         <= 1'b0;
      bus.fu_in           <= '0;
      bus.fu_weight       <= '0;
      bus.fu_in_width     <= '0;
      bus.fu_weight_width <= '0;
      bus.fu_s_in         <= 1'b0;
      bus.fu_s_weight     <= 1'b0;
    end else begin
      bus.fu_in     <= op_hs ? bus.op_in : 4'd0;
      bus.fu_weight <= op_hs ? bus.op_weight : 4'd0;
      v1_q          <= op_hs;
      v2_q          <= v1_q;
      if (v2_q) begin
        acc_q <= acc_nxt;
        if (add_ovf)
          ovf_q <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (cfg_hs) begin
            bus.fu_in_width     <= bus.cfg_in_width;
            bus.fu_weight_width <= bus.cfg_weight_width;
            bus.fu_s_in         <= bus.cfg_s_in;
            bus.fu_s_weight     <= bus.cfg_s_weight;
            sgn_q       <= bus.cfg_s_in | bus.cfg_s_weight;
            len_q       <= bus.cfg_len;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cfg_ready_q <= 1'b0;
            if (bus.cfg_len == '0) begin
              state       <= DONE;
              res_valid_q <= 1'b1;
            end else begin
              state      <= RUN;
              op_ready_q <= 1'b1;
            end
          end else begin
            cfg_ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (op_hs) begin
            cnt_q <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state      <= DRAIN;
              op_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!v1_q && !v2_q) begin
            state       <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_hs) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            cfg_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fusion_dot_seq.sv
// Directed bench for fusion_dot_seq.
// Drives a 16-bit and a 10-bit accumulator instance through one mux.
module tb_fusion_dot_seq;

  logic clk;
  logic rst;
  logic sel;
  int   tests;
  int   fails;

  logic       cfg_valid;
  logic [2:0] cfg_w;
  logic       cfg_si;
  logic       cfg_sw;
  logic [7:0] cfg_len;
  logic       op_valid;
  logic [3:0] op_in;
  logic [3:0] op_weight;
  logic       res_ready;

  logic        cfg_ready_m;
  logic        op_ready_m;
  logic        res_valid_m;
  logic [15:0] res_data_m;
  logic        res_ovf_m;

  logic [3:0] va [8];
  logic [3:0] vw [8];

  fusion_dot_seq_if #(.LEN_W(8), .ACC_W(16)) b16 ();
  fusion_dot_seq_if #(.LEN_W(8), .ACC_W(10)) b10 ();

  fusion_dot_seq #(.LEN_W(8), .ACC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  fusion_dot_seq #(.LEN_W(8), .ACC_W(10)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (b10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign b16.cfg_valid        = cfg_valid & ~sel;
  assign b16.cfg_in_width     = cfg_w;
  assign b16.cfg_weight_width = cfg_w;
  assign b16.cfg_s_in         = cfg_si;
  assign b16.cfg_s_weight     = cfg_sw;
  assign b16.cfg_len          = cfg_len;
  assign b16.op_valid         = op_valid & ~sel;
  assign b16.op_in            = op_in;
  assign b16.op_weight        = op_weight;
  assign b16.res_ready        = res_ready & ~sel;

  assign b10.cfg_valid        = cfg_valid & sel;
  assign b10.cfg_in_width     = cfg_w;
  assign b10.cfg_weight_width = cfg_w;
  assign b10.cfg_s_in         = cfg_si;
  assign b10.cfg_s_weight     = cfg_sw;
  assign b10.cfg_len          = cfg_len;
  assign b10.op_valid         = op_valid & sel;
  assign b10.op_in            = op_in;
  assign b10.op_weight        = op_weight;
  assign b10.res_ready        = res_ready & sel;

  assign cfg_ready_m = sel ? b10.cfg_ready : b16.cfg_ready;
  assign op_ready_m  = sel ? b10.op_ready : b16.op_ready;
  assign res_valid_m = sel ? b10.res_valid : b16.res_valid;
  assign res_data_m  = sel ? 16'(b10.res_data) : b16.res_data;
  assign res_ovf_m   = sel ? b10.res_ovf : b16.res_ovf;

  // Reference fusion unit: registered product of the presented nibbles
  function automatic logic [7:0] fu_model(
    input logic [3:0] a,
    input logic [3:0] w,
    input logic [2:0] aw,
    input logic [2:0] ww,
    input logic       sa,
    input logic       sw
  );
    int ea, ew, h, l;
    if (aw == 3'b100 && ww == 3'b100) begin
      ea = sa ? int'($signed(a)) : int'(a);
      ew = sw ? int'($signed(w)) : int'(w);
      return 8'(ea * ew);
    end
    h = (sa ? int'($signed(a[3:2])) : int'(a[3:2])) *
        (sw ? int'($signed(w[3:2])) : int'(w[3:2]));
    l = (sa ? int'($signed(a[1:0])) : int'(a[1:0])) *
        (sw ? int'($signed(w[1:0])) : int'(w[1:0]));
    return 8'(h + l);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b16.fu_psum <= 8'd0;
      b10.fu_psum <= 8'd0;
    end else begin
      b16.fu_psum <= fu_model(b16.fu_in, b16.fu_weight,
        b16.fu_in_width, b16.fu_weight_width,
        b16.fu_s_in, b16.fu_s_weight);
      b10.fu_psum <= fu_model(b10.fu_in, b10.fu_weight,
        b10.fu_in_width, b10.fu_weight_width,
        b10.fu_s_in, b10.fu_s_weight);
    end
  end

  task automatic cfg_job(input logic si, input logic sw,
                         input logic [7:0] n);
    int k;
    cfg_valid = 1'b1;
    cfg_w     = 3'b100;
    cfg_si    = si;
    cfg_sw    = sw;
    cfg_len   = n;
    k = 0;
    while (!cfg_ready_m && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cfg_ready_m) begin
      tests++;
      fails++;
      $display("FAIL cfg_timeout: cfg_ready=%0b want 1", cfg_ready_m);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int gap);
    int k;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        op_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      op_valid  = 1'b1;
      op_in     = va[i];
      op_weight = vw[i];
      k = 0;
      while (!op_ready_m && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!op_ready_m) begin
        tests++;
        fails++;
        $display("FAIL op_timeout: op_ready=%0b want 1 at op %0d",
                 op_ready_m, i);
      end
      @(negedge clk);
    end
    op_valid  = 1'b0;
    op_in     = 4'd0;
    op_weight = 4'd0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid_m && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({b16.cfg_ready, b16.op_ready, b16.res_valid, b16.res_ovf}
        !== 4'b0) begin
      fails++;
      $display("FAIL rst_ctrl: got %b want 0000",
        {b16.cfg_ready, b16.op_ready, b16.res_valid, b16.res_ovf});
    end
    tests++;
    if (b16.res_data !== 16'd0) begin
      fails++;
      $display("FAIL rst_data: got %h want 0000", b16.res_data);
    end
    tests++;
    if ({b16.fu_in, b16.fu_weight, b16.fu_in_width,
         b16.fu_weight_width, b16.fu_s_in, b16.fu_s_weight} !== 16'd0) begin
      fails++;
      $display("FAIL rst_fu: got %h want 0000",
        {b16.fu_in, b16.fu_weight, b16.fu_in_width,
         b16.fu_weight_width, b16.fu_s_in, b16.fu_s_weight});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (b16.cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_idle_ready: got %b want 1", b16.cfg_ready);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    va[0] = 4'd3;  vw[0] = 4'd5;
    va[1] = 4'd2;  vw[1] = 4'd7;
    va[2] = 4'd15; vw[2] = 4'd1;
    va[3] = 4'd0;  vw[3] = 4'd9;
    cfg_job(1'b0, 1'b0, 8'd4);
    feed(4, 0);
    wait_res(lat);
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL uns_latency: got %0d want 3", lat);
    end
    tests++;
    if (res_data_m !== 16'd44) begin
      fails++;
      $display("FAIL uns_data: got %0d want 44", res_data_m);
    end
    tests++;
    if (res_ovf_m !== 1'b0) begin
      fails++;
      $display("FAIL uns_ovf: got %b want 0", res_ovf_m);
    end
    tests++;
    if ({cfg_ready_m, op_ready_m} !== 2'b00) begin
      fails++;
      $display("FAIL uns_done_ready: got %b want 00",
               {cfg_ready_m, op_ready_m});
    end
    release_res();
    tests++;
    if (res_valid_m !== 1'b0) begin
      fails++;
      $display("FAIL uns_release: res_valid=%b want 0", res_valid_m);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    va[0] = 4'hE; vw[0] = 4'd3;
    va[1] = 4'd7; vw[1] = 4'h8;
    cfg_job(1'b1, 1'b1, 8'd2);
    tests++;
    if ({b16.fu_in_width, b16.fu_s_in, b16.fu_s_weight} !== 5'b10011) begin
      fails++;
      $display("FAIL sgn_cfg: got %b want 10011",
        {b16.fu_in_width, b16.fu_s_in, b16.fu_s_weight});
    end
    feed(2, 0);
    wait_res(lat);
    tests++;
    if (res_data_m !== 16'hFFC2) begin
      fails++;
      $display("FAIL sgn_data: got %h want ffc2", res_data_m);
    end
    tests++;
    if (res_ovf_m !== 1'b0) begin
      fails++;
      $display("FAIL sgn_ovf: got %b want 0", res_ovf_m);
    end
    release_res();
  endtask

  task automatic test_zero_len();
    cfg_job(1'b0, 1'b0, 8'd0);
    tests++;
    if (res_valid_m !== 1'b1) begin
      fails++;
      $display("FAIL zero_valid: got %b want 1", res_valid_m);
    end
    tests++;
    if (res_data_m !== 16'd0) begin
      fails++;
      $display("FAIL zero_data: got %h want 0000", res_data_m);
    end
    op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (op_ready_m !== 1'b0) begin
        fails++;
        $display("FAIL zero_op_ready: got %b want 0", op_ready_m);
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    release_res();
  endtask

  task automatic test_gaps_hold();
    int lat;
    va[0] = 4'd3;  vw[0] = 4'd5;
    va[1] = 4'd2;  vw[1] = 4'd7;
    va[2] = 4'd15; vw[2] = 4'd1;
    va[3] = 4'd0;  vw[3] = 4'd9;
    cfg_job(1'b0, 1'b0, 8'd4);
    feed(4, 2);
    wait_res(lat);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({res_valid_m, res_data_m} !== {1'b1, 16'd44}) begin
        fails++;
        $display("FAIL hold_data: got v=%b d=%0d want v=1 d=44",
                 res_valid_m, res_data_m);
      end
      tests++;
      if (cfg_ready_m !== 1'b0) begin
        fails++;
        $display("FAIL hold_cfg_ready: got %b want 0", cfg_ready_m);
      end
      @(negedge clk);
    end
    release_res();
    @(negedge clk);
    tests++;
    if (cfg_ready_m !== 1'b1) begin
      fails++;
      $display("FAIL hold_back_idle: got %b want 1", cfg_ready_m);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [15:0] exp_d;
`ifdef FUSION_SEQ_SAT_EN
    exp_d = 16'd1023;
`else
    exp_d = 16'd101;
`endif
    sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      va[i] = 4'd15;
      vw[i] = 4'd15;
    end
    cfg_job(1'b0, 1'b0, 8'd5);
    feed(5, 0);
    wait_res(lat);
    tests++;
    if (res_data_m !== exp_d) begin
      fails++;
      $display("FAIL ovf_data: got %0d want %0d", res_data_m, exp_d);
    end
    tests++;
    if (res_ovf_m !== 1'b1) begin
      fails++;
      $display("FAIL ovf_flag: got %b want 1", res_ovf_m);
    end
    release_res();
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    va[0] = 4'd9; vw[0] = 4'd9;
    va[1] = 4'd8; vw[1] = 4'd8;
    cfg_job(1'b0, 1'b0, 8'd4);
    feed(2, 0);
    rst = 1'b1;
    #1;
    tests++;
    if ({b16.cfg_ready, b16.op_ready, b16.res_valid, b16.res_ovf,
         b16.res_data, b16.fu_in, b16.fu_weight, b16.fu_in_width,
         b16.fu_weight_width, b16.fu_s_in, b16.fu_s_weight} !== 36'd0) begin
      fails++;
      $display("FAIL mid_rst_outputs: got %h want 0",
        {b16.cfg_ready, b16.op_ready, b16.res_valid, b16.res_ovf,
         b16.res_data, b16.fu_in, b16.fu_weight, b16.fu_in_width,
         b16.fu_weight_width, b16.fu_s_in, b16.fu_s_weight});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({b16.cfg_ready, b16.res_valid} !== 2'b10) begin
      fails++;
      $display("FAIL mid_rst_idle: got %b want 10",
               {b16.cfg_ready, b16.res_valid});
    end
    va[0] = 4'hE; vw[0] = 4'd3;
    va[1] = 4'd7; vw[1] = 4'h8;
    cfg_job(1'b1, 1'b1, 8'd2);
    feed(2, 0);
    wait_res(lat);
    tests++;
    if (res_data_m !== 16'hFFC2) begin
      fails++;
      $display("FAIL mid_rst_next: got %h want ffc2", res_data_m);
    end
    release_res();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    sel       = 1'b0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_w     = 3'b100;
    cfg_si    = 1'b0;
    cfg_sw    = 1'b0;
    cfg_len   = 8'd0;
    op_valid  = 1'b0;
    op_in     = 4'd0;
    op_weight = 4'd0;
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      va[i] = 4'd0;
      vw[i] = 4'd0;
    end
    test_reset();
    test_unsigned();
    test_back_to_back();
    test_zero_len();
    test_gaps_hold();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
